spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk/mosi/cs_n (legal 2..4).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port sclk, input, 1, SPI clock from external master (asynchronous to clk).
REQ-005 SHALL have port mosi, input, 1, master-out data (asynchronous).
REQ-006 SHALL have port cs_n, input, 1, chip select, active-low (asynchronous).
REQ-007 SHALL have port miso, output, 1, slave-out data.
REQ-008 SHALL have port miso_oe, output, 1, miso drive enable (1 while selected).
REQ-009 SHALL have port tx_data, input, 32, next frame to transmit, right-aligned to frame size.
REQ-010 SHALL have port rx_data, output, 32, last complete received frame, right-aligned, upper bits zero.
REQ-011 SHALL have port rx_valid, output, 1, one-clk pulse, rx_data updated.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse, cs_n deasserted mid-frame.
REQ-013 SHALL have port busy, output, 1, high while state != IDLE.
REQ-014 SHALL have port spi_config, input, spi_config_t, uses spi_mode, spi_frame_size, bit_order; prescaler ignored.

Function
REQ-015 SHALL pass sclk, mosi, cs_n through SYNC_STAGES flops, then one extra flop for edge detection; all logic SHALL use synchronized values only.
REQ-016 SHALL derive cpol = mode 2|3, cpha = mode 1|3; frame_size 8/16/24/32 per SPI_FRAME_SIZE_*, default 8.
REQ-017 SHALL latch cpol, cpha, frame_size, bit_order on cs_n falling edge; config changes while busy SHALL have no effect until next select.
REQ-018 SHALL implement states IDLE, ACTIVE: IDLE->ACTIVE on synced cs_n fall; ACTIVE->IDLE on synced cs_n rise.
REQ-019 Leading sclk edge = transition away from cpol; trailing = transition back to cpol.
REQ-020 cpha=0: SHALL sample mosi on leading edge, shift miso on trailing edge; first bit SHALL be on miso in the cycle after cs_n fall is detected.
REQ-021 cpha=1: SHALL shift miso on leading edge (first bit presented at first leading edge), sample mosi on trailing edge.
REQ-022 SHALL capture tx_data into tx shift register on cs_n fall and on every frame boundary within one select.
REQ-023 MSB_FIRST SHALL transmit/store bit frame_size-1 first; otherwise bit 0 first.
REQ-024 SHALL count sample edges 0..frame_size-1; on the sample edge completing frame_size bits, SHALL update rx_data and pulse rx_valid the following cycle, then wrap counter to 0 and continue (back-to-back frames under one cs_n).
REQ-025 cs_n rise with bit count 0 SHALL return to IDLE silently; with bit count nonzero SHALL pulse frame_err, discard partial frame, leave rx_data unchanged.
REQ-026 SHALL ignore sclk edges while in IDLE; sclk edge coincident with cs_n fall detection SHALL be ignored.
REQ-027 miso_oe SHALL equal ACTIVE; miso SHALL be 0 when miso_oe=0.
REQ-028 Correct operation SHALL be guaranteed for sclk half-period >= SYNC_STAGES+2 clk cycles and cs_n setup/hold to first/last sclk edge >= SYNC_STAGES+2 clk.
REQ-029 rx_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-030 On rst_n=0 at clk edge: state IDLE, synchronizers loaded with cs_n=1, sclk=0, mosi=0; counter 0, rx_data 0, rx_valid 0, frame_err 0, miso 0, miso_oe 0, busy 0.
REQ-031 Reset asserted mid-frame SHALL abort without rx_valid/frame_err; after release, an already-low cs_n SHALL NOT start a frame until cs_n rises and falls again.

Verification
REQ-032 Mode 0, 8-bit, MSB_FIRST, tx_data=0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse.
REQ-033 Mode 3, 32-bit, LSB first, tx_data=0xDEADBEEF, master sends 0x12345678 -> master receives 0xDEADBEEF; rx_data=0x12345678.
REQ-034 Modes 1 and 2, 16-bit, two frames under one cs_n, tx_data changed to 0xBEEF between frames -> two rx_valid pulses; second frame transmits 0xBEEF.
REQ-035 Mode 0, 24-bit, cs_n raised after 10 bits -> frame_err pulse, rx_data unchanged, busy=0, miso_oe=0.
REQ-036 rst_n pulsed after 5 bits with cs_n held low -> all outputs reset values; further sclk edges produce no rx_valid until cs_n re-selects.
REQ-037 spi_mode changed mid-frame -> current frame completes in original mode.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave with configurable mode, frame size and bit order. All SPI pins are
// resynchronised into the clk domain; frames may run back-to-back under one select.

package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_0 = 2'd0,
    SPI_MODE_1 = 2'd1,
    SPI_MODE_2 = 2'd2,
    SPI_MODE_3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    SPI_FRAME_SIZE_8  = 2'd0,
    SPI_FRAME_SIZE_16 = 2'd1,
    SPI_FRAME_SIZE_24 = 2'd2,
    SPI_FRAME_SIZE_32 = 2'd3
  } spi_frame_size_t;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_t;

  typedef struct packed {
    spi_mode_t       spi_mode;
    spi_frame_size_t spi_frame_size;
    bit_order_t      bit_order;
    logic [7:0]      prescaler;
  } spi_config_t;

endpackage

module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy,
  input  spi_config_t spi_config
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

  // Handshake: rx_valid and frame_err are single-cycle strobes with no ready;
  // rx_data is stable from the rx_valid cycle until the next completed frame.

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  state_t      state;
  logic        cpol_q;
  logic        cpha_q;
  logic        lsb_q;
  logic [5:0]  fbits_q;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [31:0] rx_sr;
  logic        miso_q;
  logic [2:0]  settle_cnt;
  logic        armed;

  logic unused_prescaler;
  assign unused_prescaler = ^spi_config.prescaler;

  function automatic logic [5:0] frame_bits(input spi_frame_size_t fs);
    case (fs)
      SPI_FRAME_SIZE_16: return 6'd16;
      SPI_FRAME_SIZE_24: return 6'd24;
      SPI_FRAME_SIZE_32: return 6'd32;
      default:           return 6'd8;
    endcase
  endfunction

  // MSB-first words are left-aligned so the outgoing bit is always bit 31.
  function automatic logic [31:0] tx_load(input logic [31:0] data, input logic lsb,
                                          input logic [5:0] fbits);
    return lsb ? data : (data << (6'd32 - fbits));
  endfunction

  function automatic logic tx_first(input logic [31:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[31];
  endfunction

  function automatic logic [31:0] tx_next(input logic [31:0] sr, input logic lsb);
    return lsb ? (sr >> 1) : (sr << 1);
  endfunction

  logic        cfg_cpol;
  logic        cfg_cpha;
  logic        cfg_lsb;
  logic [5:0]  cfg_fbits;
  logic [31:0] cfg_tx_word;
  assign cfg_cpol    = (spi_config.spi_mode == SPI_MODE_2) || (spi_config.spi_mode == SPI_MODE_3);
  assign cfg_cpha    = (spi_config.spi_mode == SPI_MODE_1) || (spi_config.spi_mode == SPI_MODE_3);
  assign cfg_lsb     = (spi_config.bit_order == LSB_FIRST);
  assign cfg_fbits   = frame_bits(spi_config.spi_frame_size);
  assign cfg_tx_word = tx_load(tx_data, cfg_lsb, cfg_fbits);

  logic cs_fall;
  logic cs_rise;
  logic sclk_edge;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic last_bit;
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign sclk_edge   = sclk_s ^ sclk_d;
  assign lead_edge   = sclk_edge & (sclk_s != cpol_q);
  assign trail_edge  = sclk_edge & (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign last_bit    = ({1'b0, bit_cnt} == (fbits_q - 6'd1));

  // LSB-first words fill from bit 31 downward and are right-aligned on completion.
  logic [31:0] rx_shift;
  logic [31:0] rx_word;
  assign rx_shift = lsb_q ? {mosi_s, rx_sr[31:1]} : {rx_sr[30:0], mosi_s};
  assign rx_word  = lsb_q ? (rx_shift >> (6'd32 - fbits_q)) : rx_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      fbits_q    <= 6'd8;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      miso_q     <= 1'b0;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // A select already low when reset lifts must be seen high before it counts.
      if (settle_cnt != SETTLE_CYCLES) settle_cnt <= settle_cnt + 3'd1;
      if (settle_cnt == SETTLE_CYCLES && cs_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state   <= ACTIVE;
            cpol_q  <= cfg_cpol;
            cpha_q  <= cfg_cpha;
            lsb_q   <= cfg_lsb;
            fbits_q <= cfg_fbits;
            bit_cnt <= '0;
            rx_sr   <= '0;
            if (cfg_cpha) begin
              tx_sr  <= cfg_tx_word;
              miso_q <= 1'b0;
            end else begin
              tx_sr  <= tx_next(cfg_tx_word, cfg_lsb);
              miso_q <= tx_first(cfg_tx_word, cfg_lsb);
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            miso_q  <= 1'b0;
            bit_cnt <= '0;
            rx_sr   <= '0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else begin
            if (shift_edge) begin
              miso_q <= tx_first(tx_sr, lsb_q);
              tx_sr  <= tx_next(tx_sr, lsb_q);
            end
            if (sample_edge) begin
              if (last_bit) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                rx_sr    <= '0;
                tx_sr    <= tx_load(tx_data, lsb_q, fbits_q);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                rx_sr   <= rx_shift;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign miso_oe = (state == ACTIVE);
  assign miso    = miso_q & miso_oe;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives frames and the expected
// words come from the transmitted/received data masked to the frame size.

module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic        miso_oe;
  logic [31:0] tx_data = '0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;
  spi_config_t cfg;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .spi_config (cfg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rv_cnt++;
      got_q.push_back(rx_data);
    end
    if (frame_err) fe_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  logic        m_cpol;
  logic        m_cpha;
  logic [31:0] tx_w[4];
  logic [31:0] mo_w[4];
  logic [31:0] mi_w[4];
  logic [31:0] mi_acc;

  function automatic logic [31:0] fmask(input int fs);
    return (fs == 32) ? 32'hFFFF_FFFF : ((32'd1 << fs) - 32'd1);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int mode, input int fsize, input bit lsb);
    cfg.spi_mode = spi_mode_t'(mode[1:0]);
    case (fsize)
      16:      cfg.spi_frame_size = SPI_FRAME_SIZE_16;
      24:      cfg.spi_frame_size = SPI_FRAME_SIZE_24;
      32:      cfg.spi_frame_size = SPI_FRAME_SIZE_32;
      default: cfg.spi_frame_size = SPI_FRAME_SIZE_8;
    endcase
    cfg.bit_order = lsb ? LSB_FIRST : MSB_FIRST;
    cfg.prescaler = 8'($urandom);
    m_cpol = (mode == 2 || mode == 3);
    m_cpha = (mode == 1 || mode == 3);
    sclk = m_cpol;
    wait_clk(4 * HALF);
  endtask

  // Master: shifts `count` bits of out_word starting at bit position `first`,
  // collecting miso into mi_acc; tx_data takes next_tx after the first bit.
  task automatic spi_bits(input logic [31:0] out_word, input int first, input int count,
                          input int fsize, input bit lsb, input logic [31:0] next_tx);
    for (int i = first; i < first + count; i++) begin
      int b;
      b = lsb ? i : fsize - 1 - i;
      if (!m_cpha) begin
        mosi = out_word[b];
        wait_clk(HALF);
        mi_acc[b] = miso;
        sclk = ~m_cpol;
        wait_clk(HALF);
        sclk = m_cpol;
      end else begin
        sclk = ~m_cpol;
        mosi = out_word[b];
        wait_clk(HALF);
        mi_acc[b] = miso;
        sclk = m_cpol;
        wait_clk(HALF);
      end
      if (i == first) tx_data = next_tx;
    end
  endtask

  task automatic xfer(input int nframes, input int fsize, input bit lsb);
    tx_data = tx_w[0];
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int f = 0; f < nframes; f++) begin
      mi_acc = '0;
      spi_bits(mo_w[f], 0, fsize, fsize, lsb, (f + 1 < nframes) ? tx_w[f + 1] : tx_w[f]);
      mi_w[f] = mi_acc;
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(1);
    n_checks++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=%h", rx_data, 32'h0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
  endtask

  task automatic test_mode0_basic;
    int rv0;
    set_cfg(0, 8, 1'b0);
    got_q.delete();
    rv0 = rv_cnt;
    tx_w[0] = 32'hA5;
    mo_w[0] = 32'h3C;
    xfer(1, 8, 1'b0);
    n_checks++; if (mi_w[0] !== 32'hA5) begin n_fail++; $display("FAIL m0_miso_word got=%h exp=%h", mi_w[0], 32'hA5); end
    n_checks++; if (rx_data !== 32'h3C) begin n_fail++; $display("FAIL m0_rx_data got=%h exp=%h", rx_data, 32'h3C); end
    n_checks++; if (rv_cnt - rv0 !== 1) begin n_fail++; $display("FAIL m0_rx_valid_count got=%0d exp=1", rv_cnt - rv0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL m0_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_mode3_lsb32;
    set_cfg(3, 32, 1'b1);
    tx_w[0] = 32'hDEADBEEF;
    mo_w[0] = 32'h12345678;
    xfer(1, 32, 1'b1);
    n_checks++; if (mi_w[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL m3_miso_word got=%h exp=%h", mi_w[0], 32'hDEADBEEF); end
    n_checks++; if (rx_data !== 32'h12345678) begin n_fail++; $display("FAIL m3_rx_data got=%h exp=%h", rx_data, 32'h12345678); end
  endtask

  task automatic test_back_to_back;
    int rv0;
    for (int m = 1; m <= 2; m++) begin
      set_cfg(m, 16, 1'b0);
      got_q.delete();
      exp_q.delete();
      rv0 = rv_cnt;
      tx_w[0] = 32'($urandom_range(0, 16'hFFFF));
      tx_w[1] = 32'hBEEF;
      mo_w[0] = 32'($urandom_range(0, 16'hFFFF));
      mo_w[1] = 32'($urandom_range(0, 16'hFFFF));
      exp_q.push_back(mo_w[0]);
      exp_q.push_back(mo_w[1]);
      xfer(2, 16, 1'b0);
      n_checks++; if (rv_cnt - rv0 !== 2) begin n_fail++; $display("FAIL b2b_rx_valid_count mode=%0d got=%0d exp=2", m, rv_cnt - rv0); end
      n_checks++; if (mi_w[0] !== tx_w[0]) begin n_fail++; $display("FAIL b2b_miso_f0 mode=%0d got=%h exp=%h", m, mi_w[0], tx_w[0]); end
      n_checks++; if (mi_w[1] !== 32'hBEEF) begin n_fail++; $display("FAIL b2b_miso_f1 mode=%0d got=%h exp=%h", m, mi_w[1], 32'hBEEF); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = got_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_rx_word mode=%0d got=%h exp=%h", m, g, e); end
      end
    end
  endtask

  task automatic test_frame_err;
    logic [31:0] prev;
    int rv0, fe0;
    set_cfg(0, 24, 1'b0);
    tx_w[0] = 32'($urandom_range(0, 24'hFFFFFF));
    mo_w[0] = 32'($urandom_range(0, 24'hFFFFFF));
    xfer(1, 24, 1'b0);
    prev = mo_w[0];
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    tx_data = 32'h00C0FFEE;
    cs_n = 1'b0;
    wait_clk(HALF);
    mi_acc = '0;
    spi_bits(32'h00ABCDEF, 0, 10, 24, 1'b0, 32'h00C0FFEE);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_mid got=%b exp=1", busy); end
    n_checks++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL ferr_miso_oe_mid got=%b exp=1", miso_oe); end
    n_checks++; if (mi_acc[23:14] !== 10'(32'h00C0FFEE >> 14)) begin n_fail++; $display("FAIL ferr_miso_partial got=%h exp=%h", mi_acc[23:14], 10'(32'h00C0FFEE >> 14)); end
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulse_count got=%0d exp=1", fe_cnt - fe0); end
    n_checks++; if (rv_cnt - rv0 !== 0) begin n_fail++; $display("FAIL ferr_rx_valid_count got=%0d exp=0", rv_cnt - rv0); end
    n_checks++; if (rx_data !== prev) begin n_fail++; $display("FAIL ferr_rx_data_kept got=%h exp=%h", rx_data, prev); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_after got=%b exp=0", busy); end
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL ferr_miso_oe_after got=%b exp=0", miso_oe); end
  endtask

  task automatic test_reset_mid_frame;
    int rv0, fe0;
    set_cfg(0, 8, 1'b0);
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    tx_data = 32'h5A;
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'hF0, 0, 5, 8, 1'b0, 32'h5A);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(1);
    n_checks++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_rx_data got=%h exp=0", rx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso_oe got=%b exp=0", miso_oe); end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
    spi_bits(32'h96, 0, 8, 8, 1'b0, 32'h5A);
    wait_clk(HALF);
    n_checks++; if (rv_cnt - rv0 !== 0) begin n_fail++; $display("FAIL rstmid_no_rx_valid got=%0d exp=0", rv_cnt - rv0); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL rstmid_no_frame_err got=%0d exp=0", fe_cnt - fe0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_held got=%b exp=0", busy); end
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL rstmid_deselect_err got=%0d exp=0", fe_cnt - fe0); end
    tx_w[0] = 32'h69;
    mo_w[0] = 32'hC3;
    xfer(1, 8, 1'b0);
    n_checks++; if (rx_data !== 32'hC3) begin n_fail++; $display("FAIL rstmid_reselect_rx got=%h exp=%h", rx_data, 32'hC3); end
    n_checks++; if (mi_w[0] !== 32'h69) begin n_fail++; $display("FAIL rstmid_reselect_miso got=%h exp=%h", mi_w[0], 32'h69); end
  endtask

  task automatic test_mode_change;
    int rv0;
    set_cfg(0, 16, 1'b0);
    rv0 = rv_cnt;
    tx_data = 32'h1D2C;
    mo_w[0] = 32'hA0F5;
    cs_n = 1'b0;
    wait_clk(HALF);
    mi_acc = '0;
    spi_bits(mo_w[0], 0, 3, 16, 1'b0, 32'h1D2C);
    cfg.spi_mode       = SPI_MODE_3;
    cfg.spi_frame_size = SPI_FRAME_SIZE_8;
    cfg.bit_order      = LSB_FIRST;
    spi_bits(mo_w[0], 3, 13, 16, 1'b0, 32'h1D2C);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    n_checks++; if (rv_cnt - rv0 !== 1) begin n_fail++; $display("FAIL modechg_rx_valid_count got=%0d exp=1", rv_cnt - rv0); end
    n_checks++; if (rx_data !== 32'hA0F5) begin n_fail++; $display("FAIL modechg_rx_data got=%h exp=%h", rx_data, 32'hA0F5); end
    n_checks++; if (mi_acc !== 32'h1D2C) begin n_fail++; $display("FAIL modechg_miso_word got=%h exp=%h", mi_acc, 32'h1D2C); end
  endtask

  task automatic test_random;
    int sizes[4] = '{8, 16, 24, 32};
    for (int it = 0; it < 8; it++) begin
      int mode, fs, nf, rv0;
      bit lsb;
      mode = $urandom_range(0, 3);
      fs   = sizes[$urandom_range(0, 3)];
      lsb  = 1'($urandom_range(0, 1));
      nf   = $urandom_range(1, 3);
      set_cfg(mode, fs, lsb);
      got_q.delete();
      exp_q.delete();
      rv0 = rv_cnt;
      for (int f = 0; f < nf; f++) begin
        tx_w[f] = $urandom & fmask(fs);
        mo_w[f] = $urandom & fmask(fs);
        exp_q.push_back(mo_w[f]);
      end
      xfer(nf, fs, lsb);
      n_checks++; if (rv_cnt - rv0 !== nf) begin n_fail++; $display("FAIL rnd_rx_valid_count it=%0d got=%0d exp=%0d", it, rv_cnt - rv0, nf); end
      for (int f = 0; f < nf; f++) begin
        n_checks++; if (mi_w[f] !== tx_w[f]) begin n_fail++; $display("FAIL rnd_miso it=%0d mode=%0d fs=%0d lsb=%0d f=%0d got=%h exp=%h", it, mode, fs, lsb, f, mi_w[f], tx_w[f]); end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = got_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL rnd_rx it=%0d mode=%0d fs=%0d lsb=%0d got=%h exp=%h", it, mode, fs, lsb, g, e); end
      end
    end
  endtask

  task automatic test_exclusive;
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    cfg = '0;
    test_reset();
    test_mode0_basic();
    test_mode3_lsb32();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_frame();
    test_mode_change();
    test_random();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
